// File: rtl/m107_rom_fetch.sv
// m107_rom_fetch: V33 ROM read responder backed by a 64-bit line buffer.
// A miss refills the line from SDRAM over a toggle req/ack channel.
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   mem_rd            one-cycle pulse at the start of a CPU read
//   cpu_rom_memrq     ROM select, valid with mem_rd
//   rom_addr[19:0]    ROM byte address, valid with mem_rd
//   invalidate        drop the buffered line
//   dout[15:0]        read data to the CPU
//   ready             low inserts wait states
//   sdr_req           SDRAM request toggle
//   sdr_addr[23:0]    SDRAM byte address (8-byte aligned)
//   sdr_ack           SDRAM acknowledge toggle
//   sdr_data[63:0]    SDRAM line, little-endian
module m107_rom_fetch #(
    parameter logic [23:0] ROM_BASE = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_rd,
    input  logic        cpu_rom_memrq,
    input  logic [19:0] rom_addr,
    input  logic        invalidate,
    output logic [15:0] dout,
    output logic        ready,
    output logic        sdr_req,
    output logic [23:0] sdr_addr,
    input  logic        sdr_ack,
    input  logic [63:0] sdr_data
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_line_data;
    logic [16:0] r_line_tag;
    logic        r_line_valid;
    logic        r_kill;
    logic [19:1] r_addr;
    logic [15:0] r_dout;
    logic        r_sdr_req;
    logic [23:0] r_sdr_addr;

    logic        w_rd_rom;
    logic        w_hit;
    logic        w_start;
    logic        w_hit_rd;
    logic        w_ack;
    logic [5:0]  w_hit_sh;
    logic [15:0] w_hit_word;
    logic [15:0] w_fill_word;
    logic [19:0] w_line_off;

    assign w_rd_rom = mem_rd && cpu_rom_memrq;

    // An invalidate on the same edge as a read forces the read to miss.
    assign w_hit = r_line_valid && !invalidate &&
                   (r_line_tag == rom_addr[19:3]);

    assign w_hit_rd = (r_state == S_IDLE) && w_rd_rom && w_hit;
    assign w_start  = (r_state == S_IDLE) && w_rd_rom && !w_hit;
    assign w_ack    = (sdr_ack == r_sdr_req);

    // Byte offset bit 0 is masked off; byte-lane selection is the CPU's job.
    assign w_hit_sh    = {rom_addr[2:0], 3'b000} & 6'h30;
    assign w_hit_word  = 16'(r_line_data >> w_hit_sh);
    assign w_fill_word = 16'(sdr_data >> {r_addr[2:1], 4'b0000});
    assign w_line_off  = {rom_addr[19:3], 3'b000};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_start) w_next = S_FILL;
            S_FILL: if (w_ack)   w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b1;
        unique case (r_state)
            S_IDLE:  ready = 1'b1;
            S_FILL:  ready = 1'b0;
            default: ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_line_data  <= '0;
            r_line_tag   <= '0;
            r_line_valid <= 1'b0;
            r_kill       <= 1'b0;
            r_addr       <= '0;
            r_dout       <= '0;
            r_sdr_req    <= 1'b0;
            r_sdr_addr   <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_kill <= 1'b0;
                if (invalidate) r_line_valid <= 1'b0;
                if (w_hit_rd) r_dout <= w_hit_word;
                if (w_start) begin
                    r_addr     <= rom_addr[19:1];
                    r_sdr_addr <= ROM_BASE + {4'h0, w_line_off};
                    r_sdr_req  <= ~r_sdr_req;
                end
            end else begin
                if (invalidate) r_kill <= 1'b1;
                if (w_ack) begin
                    r_line_data  <= sdr_data;
                    r_line_tag   <= r_addr[19:3];
                    // A kill seen at any point in the fill, including
                    // the completing cycle, leaves the line invalid.
                    r_line_valid <= !(r_kill || invalidate);
                    r_dout       <= w_fill_word;
                    r_kill       <= 1'b0;
                end
            end
        end
    end

    assign dout     = r_dout;
    assign sdr_req  = r_sdr_req;
    assign sdr_addr = r_sdr_addr;

endmodule

// File: tb/tb_m107_rom_fetch.sv
// tb_m107_rom_fetch: directed bench for m107_rom_fetch.
// Inputs driven on negedge; outputs sampled on negedge.
module tb_m107_rom_fetch;

    logic        clk;
    logic        reset_n;
    logic        mem_rd;
    logic        cpu_rom_memrq;
    logic [19:0] rom_addr;
    logic        invalidate;
    logic        sdr_ack;
    logic [63:0] sdr_data;

    logic [15:0] dout0, dout1, dout2;
    logic        ready0, ready1, ready2;
    logic        req0, req1, req2;
    logic [23:0] sa0, sa1, sa2;

    int checks = 0;
    int errors = 0;

    m107_rom_fetch u_dut (
        .clk(clk), .reset_n(reset_n), .mem_rd(mem_rd),
        .cpu_rom_memrq(cpu_rom_memrq), .rom_addr(rom_addr),
        .invalidate(invalidate), .dout(dout0), .ready(ready0),
        .sdr_req(req0), .sdr_addr(sa0), .sdr_ack(sdr_ack),
        .sdr_data(sdr_data)
    );

    m107_rom_fetch #(.ROM_BASE(24'h100000)) u_b1 (
        .clk(clk), .reset_n(reset_n), .mem_rd(mem_rd),
        .cpu_rom_memrq(cpu_rom_memrq), .rom_addr(rom_addr),
        .invalidate(invalidate), .dout(dout1), .ready(ready1),
        .sdr_req(req1), .sdr_addr(sa1), .sdr_ack(sdr_ack),
        .sdr_data(sdr_data)
    );

    m107_rom_fetch #(.ROM_BASE(24'hFFFF00)) u_b2 (
        .clk(clk), .reset_n(reset_n), .mem_rd(mem_rd),
        .cpu_rom_memrq(cpu_rom_memrq), .rom_addr(rom_addr),
        .invalidate(invalidate), .dout(dout2), .ready(ready2),
        .sdr_req(req2), .sdr_addr(sa2), .sdr_ack(sdr_ack),
        .sdr_data(sdr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Pulse mem_rd for one edge; returns at the negedge after it.
    task automatic rd(input logic [19:0] a, input logic rom,
                      input logic inv);
        @(negedge clk);
        mem_rd        = 1'b1;
        cpu_rom_memrq = rom;
        rom_addr      = a;
        invalidate    = inv;
        @(negedge clk);
        mem_rd        = 1'b0;
        cpu_rom_memrq = 1'b0;
        invalidate    = 1'b0;
    endtask

    // Called at the negedge after a miss. Drives the ack on sample
    // ack_at, optional invalidate on sample inv_at, counts ready-low.
    task automatic serve(input int ack_at, input int inv_at,
                         input logic [63:0] d, output int lowcnt);
        lowcnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (ready0) break;
            lowcnt++;
            invalidate = (k == inv_at);
            if (k == ack_at) begin
                sdr_ack  = req0;
                sdr_data = d;
            end
            @(negedge clk);
        end
        invalidate = 1'b0;
        if (!ready0) check("serve_timeout", {63'd0, ready0}, 64'd1);
    endtask

    int          lc;
    logic        req_before;
    logic [15:0] dout_before;

    initial begin
        reset_n       = 1'b0;
        mem_rd        = 1'b0;
        cpu_rom_memrq = 1'b0;
        rom_addr      = '0;
        invalidate    = 1'b0;
        sdr_ack       = 1'b0;
        sdr_data      = '0;
        repeat (2) @(negedge clk);
        check("rst_dout", 64'(dout0), 64'h0);
        check("rst_ready", 64'(ready0), 64'h1);
        check("rst_req", 64'(req0), 64'h0);
        check("rst_addr", 64'(sa0), 64'h0);
        reset_n = 1'b1;

        // cold miss
        rd(20'h00006, 1'b1, 1'b0);
        check("miss_ready", 64'(ready0), 64'h0);
        check("miss_req", 64'(req0), 64'h1);
        check("miss_addr", 64'(sa0), 64'h000000);
        serve(4, -1, 64'h4444_3333_2222_1111, lc);
        check("miss_lowcnt", 64'(lc), 64'd5);
        check("miss_dout", 64'(dout0), 64'h4444);

        // hit
        rd(20'h00002, 1'b1, 1'b0);
        check("hit_ready", 64'(ready0), 64'h1);
        check("hit_dout", 64'(dout0), 64'h2222);
        check("hit_req", 64'(req0), 64'h1);
        rd(20'h00000, 1'b1, 1'b0);
        check("hit2_dout", 64'(dout0), 64'h1111);

        // base offset and wrap
        rd(20'hFFFF8, 1'b1, 1'b0);
        check("base_addr0", 64'(sa0), 64'h0FFFF8);
        check("base_addr1", 64'(sa1), 64'h1FFFF8);
        check("base_req", 64'(req0), 64'h0);
        serve(1, -1, 64'hDDDD_CCCC_BBBB_AAAA, lc);
        check("base_lowcnt", 64'(lc), 64'd2);
        check("base_dout", 64'(dout1), 64'hAAAA);
        rd(20'h00100, 1'b1, 1'b0);
        check("wrap_addr2", 64'(sa2), 64'h000000);
        check("wrap_addr0", 64'(sa0), 64'h000100);
        serve(0, -1, 64'h0123_4567_89AB_CDEF, lc);
        check("wrap_dout", 64'(dout0), 64'hCDEF);

        // non-ROM read
        req_before  = req0;
        dout_before = dout0;
        rd(20'h00106, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("nrom_ready", 64'(ready0), 64'h1);
            check("nrom_dout", 64'(dout0), 64'(dout_before));
            check("nrom_req", 64'(req0), 64'(req_before));
            @(negedge clk);
        end

        // invalidate during fill
        rd(20'h00012, 1'b1, 1'b0);
        check("kill_ready", 64'(ready0), 64'h0);
        check("kill_req", 64'(req0), 64'h0);
        serve(2, 0, 64'h8888_7777_6666_5555, lc);
        check("kill_dout", 64'(dout0), 64'h6666);
        check("kill_readyup", 64'(ready0), 64'h1);
        rd(20'h00010, 1'b1, 1'b0);
        check("kill_rmiss", 64'(ready0), 64'h0);
        check("kill_rreq", 64'(req0), 64'h1);
        serve(1, -1, 64'h8888_7777_6666_5555, lc);
        check("kill_rdout", 64'(dout0), 64'h5555);
        rd(20'h00016, 1'b1, 1'b0);
        check("kill_hit", 64'(ready0), 64'h1);
        check("kill_hitd", 64'(dout0), 64'h8888);

        // simultaneous invalidate and hit
        rd(20'h00000, 1'b1, 1'b0);
        serve(1, -1, 64'hFACE_B00C_CAFE_BEEF, lc);
        check("sim_fill", 64'(dout0), 64'hBEEF);
        rd(20'h00004, 1'b1, 1'b1);
        check("sim_ready", 64'(ready0), 64'h0);
        check("sim_req", 64'(req0), 64'h1);
        serve(0, -1, 64'h1234_5678_9ABC_DEF0, lc);
        check("sim_dout", 64'(dout0), 64'h5678);

        // reset mid-fill
        rd(20'h00040, 1'b1, 1'b0);
        check("rmf_ready0", 64'(ready0), 64'h0);
        reset_n = 1'b0;
        sdr_ack = 1'b0;
        #1;
        check("rmf_ready", 64'(ready0), 64'h1);
        check("rmf_req", 64'(req0), 64'h0);
        check("rmf_dout", 64'(dout0), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        sdr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        sdr_data = '0;
        @(negedge clk);
        check("stale_dout", 64'(dout0), 64'h0);
        check("stale_ready", 64'(ready0), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
